// File: rtl/prog_loader.sv
// prog_loader: boot / program-load controller for the pipelined core.
//
// Takes a byte stream over a valid/ready handshake, writes it byte by byte
// into the core's instruction RAM (byte n -> address n), keeps the core in
// reset while loading, and releases it a fixed number of cycles after the
// last write.
//
// Ports:
//   clk, rst_n      system clock (rising edge), async active-low reset
//   start_i         one-cycle pulse, begins or restarts a load
//   len_i           byte count sampled with start_i; 0 means 2^ADDR_W
//   in_valid_i      byte source has data
//   in_data_i       stream byte
//   in_ready_o      controller accepts a byte this cycle
//   inst_we_o       instruction-RAM write strobe (one cycle per byte)
//   inst_address_o  instruction-RAM byte address
//   inst_data_o     instruction-RAM write data
//   core_rst_n_o    active-low reset to the core
//   busy_o          load in progress (LOAD/CHK/RELEASE)
//   loaded_o        core running (RUN)
//   err_o           checksum failure flag
//
// Optional feature macro: PROG_LOADER_CHECKSUM_EN
//   When defined, one trailing checksum byte follows the data. The data
//   bytes plus the checksum must sum to 0 mod 256, otherwise err_o is set
//   and the controller falls back to HOLD. When undefined, err_o is tied 0.
//
// State   | meaning
// HOLD    | idle after reset or failed checksum, core held in reset
// LOAD    | accepting data bytes and writing them to RAM
// CHK     | accepting the checksum byte (feature build only)
// RELEASE | core still in reset for RELEASE_CYCLES extra cycles
// RUN     | core released, program loaded

module prog_loader #(
  parameter int ADDR_W         = 7,
  parameter int RELEASE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W:0]   len_i,
  input  logic              in_valid_i,
  input  logic [7:0]        in_data_i,
  output logic              in_ready_o,
  output logic              inst_we_o,
  output logic [ADDR_W-1:0] inst_address_o,
  output logic [7:0]        inst_data_o,
  output logic              core_rst_n_o,
  output logic              busy_o,
  output logic              loaded_o,
  output logic              err_o
);

  typedef enum logic [2:0] {
    S_HOLD,
    S_LOAD,
`ifdef PROG_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_RELEASE,
    S_RUN
  } state_e;

  localparam logic [ADDR_W:0] CAP     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [3:0]      REL_T   = 4'(RELEASE_CYCLES);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   len_eff;
  logic [3:0]        tmr_q;
  logic              in_ready_q;
  logic              inst_we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        data_q;
  logic              core_rst_n_q;
  logic              busy_q;
  logic              loaded_q;
  logic              hs;
  logic              wr_hs;
  logic              last_byte;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]        sum_q;
  logic [7:0]        chk_total;
  logic              chk_hs;
  logic              chk_fail;
  logic              err_q;
`endif

  always_comb begin
    hs        = in_valid_i & in_ready_q;
    wr_hs     = hs & (state_q == S_LOAD);
    last_byte = ((cnt_q + CNT_ONE) == len_q);
    // Lengths above the RAM capacity are clamped so the address never wraps.
    len_eff   = len_i;
    if ((len_i == '0) || (len_i > CAP)) len_eff = CAP;
`ifdef PROG_LOADER_CHECKSUM_EN
    chk_hs    = hs & (state_q == S_CHK);
    chk_total = sum_q + in_data_i;
    chk_fail  = chk_hs & (chk_total != 8'h00);
`endif
    state_d = state_q;
    if (start_i) begin
      state_d = S_LOAD;
    end else begin
      unique case (state_q)
        S_HOLD, S_RUN: state_d = state_q;
        S_LOAD: begin
          if (wr_hs && last_byte) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_RELEASE;
`endif
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (chk_hs) state_d = chk_fail ? S_HOLD : S_RELEASE;
        end
`endif
        S_RELEASE: begin
          if (tmr_q == 4'd0) state_d = S_RUN;
        end
        default: state_d = S_HOLD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_HOLD;
      cnt_q        <= '0;
      len_q        <= '0;
      tmr_q        <= REL_T;
      in_ready_q   <= 1'b0;
      inst_we_q    <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      core_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
      loaded_q     <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      in_ready_q   <= (state_d == S_LOAD) | (state_d == S_CHK);
      busy_q       <= (state_d == S_LOAD) | (state_d == S_CHK) | (state_d == S_RELEASE);
`else
      in_ready_q   <= (state_d == S_LOAD);
      busy_q       <= (state_d == S_LOAD) | (state_d == S_RELEASE);
`endif
      loaded_q     <= (state_d == S_RUN);
      core_rst_n_q <= (state_d == S_RUN);

      // An accepted byte is always written, even when start aborts the load
      // in the same cycle; the source already saw it as consumed.
      inst_we_q <= wr_hs;
      if (wr_hs) begin
        addr_q <= cnt_q[ADDR_W-1:0];
        data_q <= in_data_i;
      end

      if (start_i) begin
        cnt_q <= '0;
        len_q <= len_eff;
      end else if (wr_hs) begin
        cnt_q <= cnt_q + CNT_ONE;
      end

`ifdef PROG_LOADER_CHECKSUM_EN
      if (start_i) begin
        sum_q <= '0;
        err_q <= 1'b0;
      end else begin
        if (wr_hs) sum_q <= sum_q + in_data_i;
        if (chk_fail) err_q <= 1'b1;
      end
`endif

      // Timer is preloaded outside RELEASE, so RELEASE lasts REL_T+1 cycles.
      if (state_q == S_RELEASE) begin
        if (tmr_q != 4'd0) tmr_q <= tmr_q - 4'd1;
      end else begin
        tmr_q <= REL_T;
      end
    end
  end

  assign in_ready_o     = in_ready_q;
  assign inst_we_o      = inst_we_q;
  assign inst_address_o = addr_q;
  assign inst_data_o    = data_q;
  assign core_rst_n_o   = core_rst_n_q;
  assign busy_o         = busy_q;
  assign loaded_o       = loaded_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  assign err_o          = err_q;
`else
  assign err_o          = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
`timescale 1ns/1ps
module tb_prog_loader;
  localparam int ADDR_W = 7;
  localparam int RC     = 2;

  logic              clk      = 1'b0;
  logic              rst_n    = 1'b0;
  logic              start    = 1'b0;
  logic [ADDR_W:0]   len      = '0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data  = '0;
  logic              in_ready_o;
  logic              inst_we_o;
  logic [ADDR_W-1:0] inst_address_o;
  logic [7:0]        inst_data_o;
  logic              core_rst_n_o;
  logic              busy_o;
  logic              loaded_o;
  logic              err_o;

  prog_loader #(.ADDR_W(ADDR_W), .RELEASE_CYCLES(RC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start),
    .len_i          (len),
    .in_valid_i     (in_valid),
    .in_data_i      (in_data),
    .in_ready_o     (in_ready_o),
    .inst_we_o      (inst_we_o),
    .inst_address_o (inst_address_o),
    .inst_data_o    (inst_data_o),
    .core_rst_n_o   (core_rst_n_o),
    .busy_o         (busy_o),
    .loaded_o       (loaded_o),
    .err_o          (err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int t; int a; int d; } exp_t;
  exp_t       sb[$];
  int         n_vec       = 0;
  int         n_miss      = 0;
  int         exp_addr    = 0;
  int         last_hs_cyc = 0;
  logic [7:0] dbuf [0:255];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Write-port monitor: every strobe must match the oldest pending byte,
  // including the cycle it was due in.
  always @(negedge clk) begin : mon
    exp_t e;
    if (inst_we_o === 1'b1) begin
      check("we_expected", 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("we_cycle", 64'(cyc), 64'(e.t));
        check("we_addr", 64'(inst_address_o), 64'(e.a));
        check("we_data", 64'(inst_data_o), 64'(e.d));
      end
    end
  end

  task automatic do_start(input int l);
    start    = 1'b1;
    len      = (ADDR_W+1)'(l);
    exp_addr = 0;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  task automatic send(input int n, input bit toggle);
    int i = 0;
    int spent = 0;
    bit ph = 1'b0;
    while (i < n && spent < 1000) begin
      in_valid = toggle ? ph : 1'b1;
      ph       = ~ph;
      in_data  = in_valid ? dbuf[i] : 8'($urandom_range(0, 255));
      @(negedge clk);
      if (in_valid && in_ready_o) begin
        sb.push_back('{t: cyc + 1, a: exp_addr, d: int'(dbuf[i])});
        exp_addr++;
        last_hs_cyc = cyc;
        i++;
      end
      @(posedge clk); #1;
      spent++;
    end
    in_valid = 1'b0;
    check("send_done", 64'(i), 64'(n));
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  function automatic logic [7:0] csum(input int n);
    logic [7:0] s = 8'd0;
    for (int i = 0; i < n; i++) s = s + dbuf[i];
    return 8'(8'd0 - s);
  endfunction

  task automatic send_chk(input logic [7:0] b);
    bit done = 1'b0;
    int spent = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!done && spent < 50) begin
      @(negedge clk);
      if (in_ready_o) begin
        done = 1'b1;
        last_hs_cyc = cyc;
      end
      @(posedge clk); #1;
      spent++;
    end
    in_valid = 1'b0;
    check("chk_accepted", 64'(done), 64'(1));
  endtask
`endif

  // Core reset must first read 1 at (last accepted byte cycle) + 2 + RC.
  task automatic wait_release();
    int spent = 0;
    int exp_c = last_hs_cyc + 2 + RC;
    do begin
      @(negedge clk);
      spent++;
    end while (!core_rst_n_o && spent < 60);
    check("release_cyc", 64'(cyc), 64'(exp_c));
    check("run_flags", 64'({loaded_o, busy_o, in_ready_o, inst_we_o, err_o}), 64'(5'b10000));
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset
    @(negedge clk);
    check("reset_outs", 64'({in_ready_o, inst_we_o, inst_address_o, inst_data_o,
                             core_rst_n_o, busy_o, loaded_o, err_o}), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("hold_idle", 64'({core_rst_n_o, in_ready_o, busy_o, loaded_o}), 64'(0));
    @(posedge clk); #1;

    // Basic 4-byte load, valid held high
    dbuf[0] = 8'h13; dbuf[1] = 8'h00; dbuf[2] = 8'h00; dbuf[3] = 8'h00;
    do_start(4);
    send(4, 1'b0);
    @(negedge clk);
`ifdef PROG_LOADER_CHECKSUM_EN
    check("ready_after_data", 64'(in_ready_o), 64'(1));
`else
    check("ready_after_data", 64'(in_ready_o), 64'(0));
`endif
    @(posedge clk); #1;
`ifdef PROG_LOADER_CHECKSUM_EN
    send_chk(csum(4));
`endif
    wait_release();

    // len=0 means full capacity, valid toggling
    for (int i = 0; i < 128; i++) dbuf[i] = 8'($urandom_range(0, 255));
    do_start(0);
    send(128, 1'b1);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_chk(csum(128));
`endif
    wait_release();
    check("last_addr", 64'(inst_address_o), 64'(127));
    check("sb_drain_full", 64'(sb.size()), 64'(0));

    // Restart from RUN
    dbuf[0] = 8'hA5; dbuf[1] = 8'h5A;
    do_start(2);
    @(negedge clk);
    check("rerun_rst", 64'({core_rst_n_o, loaded_o, busy_o}), 64'(3'b001));
    @(posedge clk); #1;
    send(2, 1'b0);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_chk(csum(2));
`endif
    wait_release();

    // Abort: restart coincides with the third accepted byte
    for (int i = 0; i < 8; i++) dbuf[i] = 8'((i + 1) * 8'h11);
    do_start(8);
    send(2, 1'b0);
    in_valid = 1'b1;
    in_data  = dbuf[2];
    start    = 1'b1;
    len      = (ADDR_W+1)'(2);
    @(negedge clk);
    check("abort_ready", 64'(in_ready_o), 64'(1));
    sb.push_back('{t: cyc + 1, a: exp_addr, d: int'(dbuf[2])});
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b0;
    exp_addr = 0;
    dbuf[0] = 8'hC3; dbuf[1] = 8'h3C;
    send(2, 1'b0);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_chk(csum(2));
`endif
    wait_release();
    check("sb_drain_abort", 64'(sb.size()), 64'(0));

`ifdef PROG_LOADER_CHECKSUM_EN
    // Checksum pass and fail
    dbuf[0] = 8'h10; dbuf[1] = 8'h20;
    do_start(2);
    send(2, 1'b0);
    send_chk(8'hD0);
    wait_release();
    do_start(2);
    send(2, 1'b0);
    send_chk(8'hD1);
    @(negedge clk);
    check("chk_fail_err", 64'({err_o, busy_o, loaded_o, in_ready_o}), 64'(4'b1000));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("chk_fail_hold", 64'(core_rst_n_o), 64'(0));
    end
    @(posedge clk); #1;
    do_start(2);
    @(negedge clk);
    check("err_cleared", 64'(err_o), 64'(0));
    @(posedge clk); #1;
`endif

    // Asynchronous reset in the middle of a load
    for (int i = 0; i < 8; i++) dbuf[i] = 8'(8'hF0 - i);
    do_start(8);
    send(3, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", 64'({in_ready_o, inst_we_o, inst_address_o, inst_data_o,
                            core_rst_n_o, busy_o, loaded_o, err_o}), 64'(0));
    check("sb_drain_rst", 64'(sb.size()), 64'(0));
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 8'h77;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_ready", 64'({in_ready_o, core_rst_n_o}), 64'(0));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
